gf_2ton_koa_splitter_seq: RTL and testbench

//   Karatsuba operand splitter: front end of the GF(2^N) KOA multiplier; the merger is the back end.
//   - Accepts one operand pair A,B (NB_DATA bits each).
//   - Emits the three half-width sub-products' operand pairs serially: LL, HH, MM.
//   - Each pair is tagged so a single shared half-width multiplier and the downstream merger can reassemble it.

---
 rtl/gf_koa_pkg.sv | 20 ++
 rtl/gf_2ton_koa_term_sel.sv | 37 +++
 rtl/gf_2ton_koa_splitter_seq.sv | 130 +++++++++++++
 tb/tb_gf_2ton_koa_splitter_seq.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gf_koa_pkg.sv
// Shared definitions for the GF(2^N) Karatsuba splitter/merger pair:
// term tags and splitter FSM state encodings.
package gf_koa_pkg;

    localparam int unsigned NB_TERM = 2;

    typedef enum logic [NB_TERM-1:0] {
        TERM_LL = 2'd0,
        TERM_HH = 2'd1,
        TERM_MM = 2'd2
    } term_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EMIT_LL = 2'd1,
        ST_EMIT_HH = 2'd2,
        ST_EMIT_MM = 2'd3
    } state_e;

endpackage

// File: rtl/gf_2ton_koa_term_sel.sv
// Combinational selection of the half-width operand pair for one Karatsuba term.
// The middle term uses the GF(2) sum (XOR) of the operand halves.
module gf_2toN_koa_term_sel
    import gf_koa_pkg::*;
#(
    parameter int unsigned NB_DATA = 128
) (
    input  logic [NB_DATA-1:0]   i_data_a,
    input  logic [NB_DATA-1:0]   i_data_b,
    input  term_e                i_term,
    output logic [NB_DATA/2-1:0] o_sub_a,
    output logic [NB_DATA/2-1:0] o_sub_b
);

    localparam int unsigned H = NB_DATA / 2;

    always_comb begin
        o_sub_a = '0;
        o_sub_b = '0;
        case (i_term)
            TERM_LL: begin
                o_sub_a = i_data_a[H-1:0];
                o_sub_b = i_data_b[H-1:0];
            end
            TERM_HH: begin
                o_sub_a = i_data_a[NB_DATA-1:H];
                o_sub_b = i_data_b[NB_DATA-1:H];
            end
            TERM_MM: begin
                o_sub_a = i_data_a[H-1:0] ^ i_data_a[NB_DATA-1:H];
                o_sub_b = i_data_b[H-1:0] ^ i_data_b[NB_DATA-1:H];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/gf_2ton_koa_splitter_seq.sv
// Karatsuba operand splitter: serialises LL, HH, MM half-width operand pairs.
// Optional macro GF_KOA_SPLITTER_OPCOUNT_EN adds a saturating o_op_count port.
module gf_2ton_koa_splitter_seq #(
    parameter int unsigned NB_DATA = 128,
    parameter int unsigned NB_TERM = 2
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic [NB_DATA-1:0]   i_data_a,
    input  logic [NB_DATA-1:0]   i_data_b,
    input  logic                 i_valid,
    output logic                 o_ready,
    output logic [NB_DATA/2-1:0] o_sub_a,
    output logic [NB_DATA/2-1:0] o_sub_b,
    output logic [NB_TERM-1:0]   o_term,
    output logic                 o_last,
    output logic                 o_valid,
    input  logic                 i_ready
`ifdef GF_KOA_SPLITTER_OPCOUNT_EN
    ,
    output logic [31:0]          o_op_count
`endif
);

    import gf_koa_pkg::*;

    localparam int unsigned H = NB_DATA / 2;

    state_e             state_q, state_d;
    logic [NB_DATA-1:0] hold_a_q, hold_a_d;
    logic [NB_DATA-1:0] hold_b_q, hold_b_d;
    logic               valid_q, valid_d;
    logic               last_q, last_d;
    term_e              term_q, term_d;
    logic [H-1:0]       sub_a_q, sub_a_d, sel_a;
    logic [H-1:0]       sub_b_q, sub_b_d, sel_b;
    logic               in_fire, out_fire;

    assign o_ready  = !i_reset && ((state_q == ST_IDLE) ||
                                   ((state_q == ST_EMIT_MM) && i_ready));
    assign in_fire  = i_valid && o_ready;
    assign out_fire = valid_q && i_ready;

    always_comb begin
        state_d  = state_q;
        hold_a_d = hold_a_q;
        hold_b_d = hold_b_q;
        if (in_fire) begin
            hold_a_d = i_data_a;
            hold_b_d = i_data_b;
        end
        case (state_q)
            ST_IDLE:    if (in_fire)  state_d = ST_EMIT_LL;
            ST_EMIT_LL: if (out_fire) state_d = ST_EMIT_HH;
            ST_EMIT_HH: if (out_fire) state_d = ST_EMIT_MM;
            ST_EMIT_MM: if (out_fire) state_d = in_fire ? ST_EMIT_LL : ST_IDLE;
            default:                  state_d = ST_IDLE;
        endcase

        // Output registers load from next-state values so the LL term is visible one cycle after in_fire.
        valid_d = 1'b1;
        last_d  = 1'b0;
        term_d  = TERM_LL;
        case (state_d)
            ST_IDLE:    valid_d = 1'b0;
            ST_EMIT_LL: term_d  = TERM_LL;
            ST_EMIT_HH: term_d  = TERM_HH;
            ST_EMIT_MM: begin
                term_d = TERM_MM;
                last_d = 1'b1;
            end
            default:    valid_d = 1'b0;
        endcase
        sub_a_d = valid_d ? sel_a : '0;
        sub_b_d = valid_d ? sel_b : '0;
    end

    gf_2toN_koa_term_sel #(
        .NB_DATA(NB_DATA)
    ) u_term_sel (
        .i_data_a(hold_a_d),
        .i_data_b(hold_b_d),
        .i_term  (term_d),
        .o_sub_a (sel_a),
        .o_sub_b (sel_b)
    );

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q  <= ST_IDLE;
            hold_a_q <= '0;
            hold_b_q <= '0;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
            term_q   <= TERM_LL;
            sub_a_q  <= '0;
            sub_b_q  <= '0;
        end else begin
            state_q  <= state_d;
            hold_a_q <= hold_a_d;
            hold_b_q <= hold_b_d;
            valid_q  <= valid_d;
            last_q   <= last_d;
            term_q   <= term_d;
            sub_a_q  <= sub_a_d;
            sub_b_q  <= sub_b_d;
        end
    end

    assign o_valid = valid_q;
    assign o_last  = last_q;
    assign o_term  = NB_TERM'(term_q);
    assign o_sub_a = sub_a_q;
    assign o_sub_b = sub_b_q;

`ifdef GF_KOA_SPLITTER_OPCOUNT_EN
    logic [31:0] op_count_q;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            op_count_q <= '0;
        end else if (out_fire && (state_q == ST_EMIT_MM) && (op_count_q != '1)) begin
            op_count_q <= op_count_q + 32'd1;
        end
    end

    assign o_op_count = op_count_q;
`endif

endmodule

// File: tb/tb_gf_2ton_koa_splitter_seq.sv
// Self-checking bench for gf_2ton_koa_splitter_seq at NB_DATA=8 (H=4).
// Accepted operands push their three expected terms into a scoreboard popped on each out_fire.
module tb_gf_2ton_koa_splitter_seq;

    typedef struct packed {
        logic [1:0] term;
        logic [3:0] a;
        logic [3:0] b;
        logic       last;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] data_a, data_b;
    logic       in_valid, in_ready;
    logic [3:0] sub_a, sub_b;
    logic [1:0] term;
    logic       last, out_valid, out_ready;
`ifdef GF_KOA_SPLITTER_OPCOUNT_EN
    logic [31:0] op_count;
`endif

    int   n_cmp = 0;
    int   n_err = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    gf_2ton_koa_splitter_seq #(
        .NB_DATA(8),
        .NB_TERM(2)
    ) dut (
        .i_clock (clk),
        .i_reset (rst),
        .i_data_a(data_a),
        .i_data_b(data_b),
        .i_valid (in_valid),
        .o_ready (in_ready),
        .o_sub_a (sub_a),
        .o_sub_b (sub_b),
        .o_term  (term),
        .o_last  (last),
        .o_valid (out_valid),
        .i_ready (out_ready)
`ifdef GF_KOA_SPLITTER_OPCOUNT_EN
        ,
        .o_op_count(op_count)
`endif
    );

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL sb_unexpected: got term=%0d a=%h b=%h last=%b, required no output",
                         term, sub_a, sub_b, last);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if ({term, sub_a, sub_b, last} !== e) begin
                    n_err++;
                    $display("FAIL sb_term: got term=%0d a=%h b=%h last=%b, required term=%0d a=%h b=%h last=%b",
                             term, sub_a, sub_b, last, e.term, e.a, e.b, e.last);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offers an operand; returns one step after the accepting edge (LL then on the outputs).
    task automatic send(input logic [7:0] a, input logic [7:0] b, output int waited);
        bit done = 0;
        data_a   = a;
        data_b   = b;
        in_valid = 1'b1;
        waited   = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (in_ready) begin
                sb.push_back('{2'd0, a[3:0], b[3:0], 1'b0});
                sb.push_back('{2'd1, a[7:4], b[7:4], 1'b0});
                sb.push_back('{2'd2, a[3:0] ^ a[7:4], b[3:0] ^ b[7:4], 1'b1});
                done = 1;
            end else begin
                waited++;
            end
            step();
        end
        if (!done) begin
            n_cmp++;
            n_err++;
            $display("FAIL send_timeout: operand a=%h never accepted, required acceptance", a);
        end
    endtask

    task automatic wait_idle();
        bit idle = 0;
        for (int i = 0; i < 40 && !idle; i++) begin
            @(negedge clk);
            if (!out_valid) idle = 1;
        end
        if (!idle) begin
            n_cmp++;
            n_err++;
            $display("FAIL idle_timeout: o_valid still 1, required 0");
        end
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; data_a = '0; data_b = '0;
        step();
        step();
        @(negedge clk);
        n_cmp++;
        if ({out_valid, last, term, sub_a, sub_b, in_ready} !== 13'b0) begin
            n_err++;
            $display("FAIL reset_state: got valid=%b last=%b term=%0d a=%h b=%h ready=%b, required all 0",
                     out_valid, last, term, sub_a, sub_b, in_ready);
        end
        step();
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_ready: got %b, required 1", in_ready);
        end
        step();
    endtask

    task automatic test_single();
        logic [3:0] ea [3] = '{4'h5, 4'hA, 4'hF};
        logic [3:0] eb [3] = '{4'hC, 4'h3, 4'hF};
        int w;
        send(8'hA5, 8'h3C, w);
        in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_cmp++;
            if ({out_valid, term, sub_a, sub_b, last} !== {1'b1, 2'(k), ea[k], eb[k], k == 2}) begin
                n_err++;
                $display("FAIL single_term%0d: got valid=%b term=%0d a=%h b=%h last=%b, required 1 %0d %h %h %b",
                         k, out_valid, term, sub_a, sub_b, last, k, ea[k], eb[k], k == 2);
            end
        end
        @(negedge clk);
        n_cmp++;
        if ({out_valid, in_ready} !== 2'b01) begin
            n_err++;
            $display("FAIL single_idle: got valid=%b ready=%b, required 0 1", out_valid, in_ready);
        end
        step();
    endtask

    task automatic test_back_to_back();
        int w;
        send(8'hA5, 8'h3C, w);
        send(8'h01, 8'h80, w);
        in_valid = 1'b0;
        n_cmp++;
        if (w !== 2) begin
            n_err++;
            $display("FAIL b2b_accept: waited %0d cycles, required 2 (accept on MM)", w);
        end
        @(negedge clk);
        n_cmp++;
        if ({out_valid, term, sub_a, sub_b} !== {1'b1, 2'd0, 4'h1, 4'h0}) begin
            n_err++;
            $display("FAIL b2b_no_bubble: got valid=%b term=%0d a=%h b=%h, required 1 0 1 0",
                     out_valid, term, sub_a, sub_b);
        end
        wait_idle();
    endtask

    task automatic test_backpressure();
        int w;
        send(8'hA5, 8'h3C, w);
        in_valid = 1'b0;
        step();
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (k == 4) out_ready = 1'b1;
            @(negedge clk);
            n_cmp++;
            if ({out_valid, term, sub_a, sub_b, last} !== {1'b1, 2'd1, 4'hA, 4'h3, 1'b0}) begin
                n_err++;
                $display("FAIL bp_hold%0d: got valid=%b term=%0d a=%h b=%h last=%b, required 1 1 a 3 0",
                         k, out_valid, term, sub_a, sub_b, last);
            end
            step();
        end
        @(negedge clk);
        n_cmp++;
        if ({out_valid, term, sub_a, sub_b, last} !== {1'b1, 2'd2, 4'hF, 4'hF, 1'b1}) begin
            n_err++;
            $display("FAIL bp_mm: got valid=%b term=%0d a=%h b=%h last=%b, required 1 2 f f 1",
                     out_valid, term, sub_a, sub_b, last);
        end
        wait_idle();
    endtask

    task automatic test_reset_mid();
        logic [3:0] ea [3] = '{4'hF, 4'hF, 4'h0};
        logic [3:0] eb [3] = '{4'hF, 4'h0, 4'hF};
        int w;
        send(8'hA5, 8'h3C, w);
        in_valid = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        sb.delete();
        @(negedge clk);
        n_cmp++;
        if ({out_valid, in_ready} !== 2'b01) begin
            n_err++;
            $display("FAIL rstmid_state: got valid=%b ready=%b, required 0 1", out_valid, in_ready);
        end
        step();
        send(8'hFF, 8'h0F, w);
        in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_cmp++;
            if ({out_valid, term, sub_a, sub_b} !== {1'b1, 2'(k), ea[k], eb[k]}) begin
                n_err++;
                $display("FAIL rstmid_term%0d: got valid=%b term=%0d a=%h b=%h, required 1 %0d %h %h",
                         k, out_valid, term, sub_a, sub_b, k, ea[k], eb[k]);
            end
        end
        wait_idle();
    endtask

    task automatic test_busy_reject();
        int w;
        send(8'hA5, 8'h3C, w);
        data_a = 8'h11;
        data_b = 8'h22;
        @(negedge clk);
        n_cmp++;
        if ({in_ready, out_valid, term} !== {1'b0, 1'b1, 2'd0}) begin
            n_err++;
            $display("FAIL busy_ready: got ready=%b valid=%b term=%0d, required 0 1 0", in_ready, out_valid, term);
        end
        step();
        send(8'h11, 8'h22, w);
        in_valid = 1'b0;
        n_cmp++;
        if (w !== 1) begin
            n_err++;
            $display("FAIL busy_accept: waited %0d cycles from HH, required 1", w);
        end
        wait_idle();
    endtask

`ifdef GF_KOA_SPLITTER_OPCOUNT_EN
    task automatic test_op_count();
        int w;
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (op_count !== 32'd0) begin
            n_err++;
            $display("FAIL opcount_reset: got %0d, required 0", op_count);
        end
        step();
        send(8'h12, 8'h34, w);
        send(8'h56, 8'h78, w);
        send(8'h9A, 8'hBC, w);
        in_valid = 1'b0;
        wait_idle();
        n_cmp++;
        if (op_count !== 32'd3) begin
            n_err++;
            $display("FAIL opcount_three: got %0d, required 3", op_count);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (op_count !== 32'd0) begin
            n_err++;
            $display("FAIL opcount_rst_again: got %0d, required 0", op_count);
        end
        step();
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        test_busy_reject();
`ifdef GF_KOA_SPLITTER_OPCOUNT_EN
        test_op_count();
`endif
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL sb_drain: %0d terms still expected, required 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
